// File: rtl/key_capture.sv
// rtl/key_capture.sv - debounced push-button capture feeding a one-hot-to-binary encoder
module key_capture #(
    parameter int N          = 3,
    parameter int DEB_CYC    = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2**N-1:0]   keys_in,
    output logic [2**N-1:0]   X,
    output logic              strobe,
    output logic              busy
);

    localparam int W  = 2**N;
    localparam int CW = ($clog2(DEB_CYC) < 1) ? 1 : $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYC - 1);
    // Raw level of a released key; also the pressed-polarity inversion mask.
    localparam logic [W-1:0]  UNPRESSED = {W{ACTIVE_LOW}};

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   sync1, sync2;
    logic [W-1:0]   s;
    logic [W-1:0]   cand, cand_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [W-1:0]   x_n;
    logic           strobe_n;

    // Two-flop synchronizer, parked at the released level so reset release is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= UNPRESSED;
            sync2 <= UNPRESSED;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    // 1 = pressed regardless of board polarity.
    assign s = sync2 ^ UNPRESSED;

    // State register together with the debounce datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            X      <= '0;
            strobe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            X      <= x_n;
            strobe <= strobe_n;
            busy   <= (state_n == SETTLE);
        end
    end

    // Next-state: track a candidate pattern until it has held for DEB_CYC clocks.
    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        x_n      = X;
        strobe_n = 1'b0;
        case (state)
            IDLE: begin
                if (s != X) begin
                    cand_n  = s;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (s == X) begin
                    // Bounced back to the accepted pattern: drop the candidate.
                    state_n = IDLE;
                end else if (s != cand) begin
                    cand_n = s;
                    cnt_n  = '0;
                end else if (cnt == CNT_MAX) begin
                    x_n      = cand;
                    strobe_n = |cand;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_capture.sv
// tb/tb_key_capture.sv - self-checking bench for key_capture (N=3, DEB_CYC=4, active-low)
module tb_key_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keys_in = 8'hFF;
    logic [7:0] X;
    logic       strobe;
    logic       busy;

    always #5 clk = ~clk;

    key_capture #(.N(3), .DEB_CYC(4), .ACTIVE_LOW(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .keys_in (keys_in),
        .X       (X),
        .strobe  (strobe),
        .busy    (busy)
    );

    typedef struct {
        logic [7:0] keys;
        int         hold;
        logic [7:0] exp_x;
        int         exp_strobes;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        int         strobes;
    } exp_t;

    exp_t       exp_q[$];
    vec_t       vecs[6];
    int         nchecks = 0;
    int         nerr = 0;
    int         strobes = 0;
    int         busy_cyc = 0;
    int         xchg = 0;
    logic       cur_busy = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] last_x = 8'h00;
    int         n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge, updating the monitors.
    task automatic step();
        @(posedge clk);
        #1;
        prev_busy = cur_busy;
        cur_busy  = busy;
        if (strobe) strobes++;
        if (busy) busy_cyc++;
        if (X !== last_x) xchg++;
        last_x = X;
    endtask

    task automatic clear_mon();
        strobes  = 0;
        busy_cyc = 0;
        xchg     = 0;
    endtask

    task automatic wait_x(input logic [7:0] t, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (X !== t && cycles < 30);
    endtask

    task automatic sb_push(input logic [7:0] x, input int s);
        exp_t e;
        e.x = x;
        e.strobes = s;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_x"}, X, e.x);
            check({name, "_strobes"}, strobes, e.strobes);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h7E, 12, 8'h81, 1};
        vecs[1] = '{8'hFF, 12, 8'h00, 0};
        vecs[2] = '{8'hFE, 12, 8'h01, 1};
        vecs[3] = '{8'h00, 12, 8'hFF, 1};
        vecs[4] = '{8'h7F, 12, 8'h80, 1};
        vecs[5] = '{8'hFF, 12, 8'h00, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", X, 8'h00);
        check("reset_strobe", strobe, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Idle with no keys pressed
        clear_mon();
        repeat (50) step();
        check("idle_x", X, 8'h00);
        check("idle_strobes", strobes, 0);
        check("idle_busy_cycles", busy_cyc, 0);

        // Single press: latency, strobe coincidence, busy before acceptance
        clear_mon();
        keys_in = 8'hDF;
        wait_x(8'h20, n);
        check("press_latency", n, 7);
        check("press_strobe_with_x", strobe, 1'b1);
        check("press_busy_before", prev_busy, 1'b1);
        check("press_busy_after", busy, 1'b0);
        step();
        check("press_strobe_one_clock", strobe, 1'b0);
        check("press_strobes", strobes, 1);

        // Release back to zero
        clear_mon();
        keys_in = 8'hFF;
        wait_x(8'h00, n);
        check("release1_latency", n, 7);
        check("release1_strobes", strobes, 0);

        // Key 2 bouncing, then held
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            keys_in = (i % 2 == 0) ? 8'hFB : 8'hFF;
            repeat (2) step();
        end
        check("bounce_x_changes", xchg, 0);
        check("bounce_strobes", strobes, 0);
        check("bounce_busy_seen", busy_cyc > 0, 1'b1);
        clear_mon();
        keys_in = 8'hFB;
        sb_push(8'h04, 1);
        repeat (12) step();
        sb_check("bounce_settle");

        // Release from 04
        clear_mon();
        keys_in = 8'hFF;
        wait_x(8'h00, n);
        check("release2_latency", n, 7);
        check("release2_strobes", strobes, 0);

        // One-clock glitch from idle
        clear_mon();
        keys_in = 8'hEF;
        step();
        keys_in = 8'hFF;
        repeat (10) step();
        check("glitch_busy_seen", busy_cyc > 0, 1'b1);
        check("glitch_x_changes", xchg, 0);
        check("glitch_strobes", strobes, 0);

        // Table of steady patterns, including multi-key and all-pressed
        foreach (vecs[i]) begin
            clear_mon();
            keys_in = vecs[i].keys;
            sb_push(vecs[i].exp_x, vecs[i].exp_strobes);
            repeat (vecs[i].hold) step();
            sb_check($sformatf("vec%0d", i));
        end

        // Reset in the middle of settling, key held across reset
        clear_mon();
        keys_in = 8'hFB;
        wait_x(8'h04, n);
        check("pre_reset_x", X, 8'h04);
        clear_mon();
        keys_in = 8'hFA;
        repeat (5) step();
        check("mid_settle_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_x", X, 8'h00);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_strobe", strobe, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_x = X;
        clear_mon();
        wait_x(8'h05, n);
        check("post_reset_latency", n, 7);
        check("post_reset_strobe_with_x", strobe, 1'b1);
        step();
        check("post_reset_strobes", strobes, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
